cordic_addsub_pipe: RTL and testbench
=====================================

// Module: cordic_addsub_pipe
//
// PURPOSE
//   Parametrised, multi-lane add/subtract stage for the CORDIC calculator datapath.
//   Per lane: sum = ha_mem +/- ha_mux, or pass-through of ha_mem, selected by that lane's gt/lt.
//   Results travel down a DEPTH-stage valid/ready pipeline with per-stage bubble collapse.
//   Sits between the angle/coefficient memory + mux and the next CORDIC iteration register.
//   One instance can serve the x, y and z channels (LANES=3).
//
// PARAMETERS
//   WIDTH  6  lane data width, two's complement
//   LANES  1  independent lanes, all sharing one handshake
//   DEPTH  2  pipeline stages (>=1); also the unstalled latency in cycles
//
// PORTS
//   CLK        in   1            clock, rising edge
//   RST_N      in   1            asynchronous reset, active-low
//   in_valid   in   1            input beat valid
//   in_ready   out  1            block accepts the beat this cycle
//   ha_mem     in   LANES*WIDTH  operand A, lane i at [i*WIDTH +: WIDTH]
//   ha_mux     in   LANES*WIDTH  operand B, same packing
//   gt         in   LANES        per-lane add request
//   lt         in   LANES        per-lane subtract request
//   out_valid  out  1            output beat valid
//   out_ready  in   1            downstream accepts the output beat
//   sum        out  LANES*WIDTH  result, same packing
//   ovf        out  LANES        per-lane signed overflow of the beat on sum
//   count      out  $clog2(DEPTH+1)  number of occupied stages
//
// BEHAVIOUR
//   - Reset (RST_N=0, async): all stage valid bits, data, ovf and count go to 0; out_valid=0.
//     In-flight beats are discarded, not replayed.
//   - Op decode per lane: gt=1 -> ADD (gt has priority when both are 1); gt=0,lt=1 -> SUB;
//     gt=0,lt=0 -> PASS (sum=ha_mem, ovf=0).
//   - Arithmetic happens on the input side and is registered into stage 0.
//     Stages 1..DEPTH-1 carry data/ovf unchanged.
//   - Overflow is signed:
//       ADD: A and B have the same sign and the result sign differs.
//       SUB: A and B have different signs and the result sign differs from A.
//   - Stage k advances when ready_k = !v_k | ready_{k+1}, with ready_DEPTH = out_ready.
//     in_ready = ready_0. The ready chain is combinational.
//   - Accept: in_valid & in_ready. Emit: out_valid & out_ready. Both can occur in one cycle.
//   - Latency: exactly DEPTH cycles from accept to out_valid when never stalled.
//     Throughput: 1 beat/cycle.
//   - out_valid = v_{DEPTH-1}. sum/ovf are held stable while out_valid & !out_ready.
//   - Full: all DEPTH stages valid and out_ready=0 -> in_ready=0, nothing is overwritten.
//   - Bubbles: a gap in the pipeline is closed by upstream stages advancing while downstream is
//     stalled.
//   - count:
//       +1 on accept without emit; -1 on emit without accept; unchanged on both or neither.
//       Never exceeds DEPTH; never wraps.
//   - Order is strictly preserved: no loss, no duplication.
//
// CONFIGURATION
//   CORDIC_ADDSUB_SAT_EN defined:
//     - on overflow, the result clamps to +2^(WIDTH-1)-1 or -2^(WIDTH-1);
//     - the sign of the clamp follows the sign of A;
//     - ovf is still set.
//   Not defined: results wrap modulo 2^WIDTH and ovf flags the wrap.
//   Handshake and latency are identical in both builds.
//
// STRUCTURE
//   - cordic_pkg holds:
//     - op_e enum {OP_PASS, OP_ADD, OP_SUB};
//     - function decode_op(gt,lt);
//     - localparam-style functions for the signed max/min of a given WIDTH.
//   - Sub-module cordic_addsub_lane (combinational: A, B, op -> result, ovf, saturation under the
//     macro) is instantiated LANES times via generate.
//   - The pipeline and handshake live in cordic_addsub_pipe.
//
// TESTING  (WIDTH=6, DEPTH=2, LANES=1 unless noted)
//   1. gt=1, A=5, B=3 -> sum=8, ovf=0, out_valid exactly 2 cycles after accept.
//   2. gt=0, lt=1, A=5, B=7 -> sum=6'h3E (-2), ovf=0.
//      gt=0, lt=0, A=12 -> sum=12.
//      gt=1, lt=1, A=2, B=3 -> sum=5.
//   3. gt=1, A=31, B=1 -> wrap build: sum=6'h20, ovf=1; SAT build: sum=31, ovf=1.
//      lt=1, A=-32, B=1 -> wrap build: sum=31, ovf=1; SAT build: sum=-32, ovf=1.
//   4. LANES=3, lanes (ADD 1+1, SUB 4-6, PASS 9) in one beat -> sum lanes = {9, -2, 2}, ovf=0.
//   5. out_ready=0, offer 3 beats -> 2 accepted, in_ready=0, count=2.
//      Release out_ready -> beats 1, 2, 3 emerge in order, one per cycle, count returns to 0.
//   6. Two beats in flight, pulse RST_N low mid-cycle -> out_valid=0 and count=0 immediately,
//      with no stale beat after reset is released.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and helpers for the CORDIC add/subtract stage.
// Holds the per-lane operation encoding, the gt/lt decode, and the signed
// max/min limits used when a result is clamped.
package cordic_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'd0,
    OP_ADD  = 2'd1,
    OP_SUB  = 2'd2
  } op_e;

  // gt has priority over lt; neither selects pass-through.
  function automatic op_e decode_op(input logic gt, input logic lt);
    if (gt) return OP_ADD;
    if (lt) return OP_SUB;
    return OP_PASS;
  endfunction

  // Largest positive two's complement value of the given width.
  function automatic longint signed smax(input int unsigned width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative two's complement value of the given width.
  function automatic longint signed smin(input int unsigned width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/cordic_addsub_pipe_if.sv
// Handshake and data bundle for cordic_addsub_pipe.
//   in_valid/in_ready   : input beat handshake
//   ha_mem/ha_mux       : operands A/B, lane i at [i*WIDTH +: WIDTH]
//   gt/lt               : per-lane add/subtract requests
//   out_valid/out_ready : output beat handshake
//   sum/ovf             : result and per-lane signed overflow
//   count               : number of occupied pipeline stages
// master drives the inputs of the block, slave is the block itself.
interface cordic_addsub_pipe_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned DW = WIDTH * LANES;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    ha_mem;
  logic [DW-1:0]    ha_mux;
  logic [LANES-1:0] gt;
  logic [LANES-1:0] lt;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    sum;
  logic [LANES-1:0] ovf;
  logic [CW-1:0]    count;

  modport master (
    output in_valid, ha_mem, ha_mux, gt, lt, out_ready,
    input  in_ready, out_valid, sum, ovf, count
  );

  modport slave (
    input  in_valid, ha_mem, ha_mux, gt, lt, out_ready,
    output in_ready, out_valid, sum, ovf, count
  );
endinterface

// File: rtl/cordic_addsub_lane.sv
// One lane of the add/subtract stage (purely combinational).
//   a, b   : two's complement operands
//   op     : PASS / ADD / SUB
//   res_c  : result (wraps, or clamps when CORDIC_ADDSUB_SAT_EN is defined)
//   ovf_c  : signed overflow of the selected operation
// Build option: CORDIC_ADDSUB_SAT_EN clamps overflowed results toward the sign of a.
module cordic_addsub_lane
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  output logic [WIDTH-1:0] res_c,
  output logic             ovf_c
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] add_r;
  logic [WIDTH-1:0] sub_r;

  // Operation select and signed overflow detection.
  always_comb begin
    add_r = a + b;
    sub_r = a - b;
    res_c = a;
    ovf_c = 1'b0;
    case (op)
      OP_ADD: begin
        res_c = add_r;
        ovf_c = (a[MSB] == b[MSB]) && (add_r[MSB] != a[MSB]);
      end
      OP_SUB: begin
        res_c = sub_r;
        ovf_c = (a[MSB] != b[MSB]) && (sub_r[MSB] != a[MSB]);
      end
      default: ;
    endcase
`ifdef CORDIC_ADDSUB_SAT_EN
    // An overflow always moves away from a's sign, so clamp on a's side.
    if (ovf_c) res_c = a[MSB] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
`endif
  end

endmodule

// File: rtl/cordic_addsub_pipe.sv
// Multi-lane add/subtract stage with a DEPTH-stage valid/ready pipeline.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   bus        : cordic_addsub_pipe_if slave (operands, handshakes, sum/ovf/count)
// Arithmetic is done on the input side and registered into stage 0; later
// stages carry the beat unchanged. Each stage advances when it is empty or the
// stage below it advances, so bubbles collapse under back-pressure.
// Build option: CORDIC_ADDSUB_SAT_EN (saturating results, see cordic_addsub_lane).
module cordic_addsub_pipe
  import cordic_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 2
) (
  input logic                  CLK,
  input logic                  RST_N,
  cordic_addsub_pipe_if.slave  bus
);
  localparam int unsigned DW = WIDTH * LANES;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] v_q;
  logic [DW-1:0]    data_q [DEPTH];
  logic [LANES-1:0] ovf_q  [DEPTH];
  logic [CW-1:0]    count_q;

  logic [DEPTH:0]   rdy;
  logic [DW-1:0]    res_c;
  logic [LANES-1:0] ovf_c;
  op_e              op_c [LANES];
  logic             accept;
  logic             emit;

  // Per-lane decode and arithmetic.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign op_c[i] = decode_op(bus.gt[i], bus.lt[i]);

    cordic_addsub_lane #(.WIDTH(WIDTH)) u_lane (
      .a     (bus.ha_mem[i*WIDTH +: WIDTH]),
      .b     (bus.ha_mux[i*WIDTH +: WIDTH]),
      .op    (op_c[i]),
      .res_c (res_c[i*WIDTH +: WIDTH]),
      .ovf_c (ovf_c[i])
    );
  end

  // Ready chain, flattened: stage k can move if out_ready or any stage at or below k is empty.
  always_comb begin
    for (int k = 0; k <= int'(DEPTH); k++) begin
      rdy[k] = bus.out_ready;
      for (int j = k; j < int'(DEPTH); j++) begin
        if (!v_q[j]) rdy[k] = 1'b1;
      end
    end
  end

  assign accept = bus.in_valid & rdy[0];
  assign emit   = v_q[DEPTH-1] & bus.out_ready;

  // Pipeline stages and occupancy counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q     <= '0;
      count_q <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
        ovf_q[k]  <= '0;
      end
    end else begin
      if (rdy[0]) begin
        v_q[0] <= bus.in_valid;
        if (bus.in_valid) begin
          data_q[0] <= res_c;
          ovf_q[0]  <= ovf_c;
        end
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (rdy[k]) begin
          v_q[k] <= v_q[k-1];
          if (v_q[k-1]) begin
            data_q[k] <= data_q[k-1];
            ovf_q[k]  <= ovf_q[k-1];
          end
        end
      end
      case ({accept, emit})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.sum       = data_q[DEPTH-1];
  assign bus.ovf       = ovf_q[DEPTH-1];
  assign bus.count     = count_q;

endmodule

// File: tb/tb_cordic_addsub_pipe.sv
// Directed bench for cordic_addsub_pipe: a single-lane instance (WIDTH=6, DEPTH=2)
// driven from a vector table plus stall and reset sequences, and a three-lane
// instance for mixed-operation beats. Expectations follow CORDIC_ADDSUB_SAT_EN.
module tb_cordic_addsub_pipe;

  logic CLK;
  logic RST_N;

  int n_vec = 0;
  int n_err = 0;

  cordic_addsub_pipe_if #(.WIDTH(6), .LANES(1), .DEPTH(2)) bus1 ();
  cordic_addsub_pipe_if #(.WIDTH(6), .LANES(3), .DEPTH(2)) bus3 ();

  cordic_addsub_pipe #(.WIDTH(6), .LANES(1), .DEPTH(2)) u_dut1 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus1)
  );

  cordic_addsub_pipe #(.WIDTH(6), .LANES(3), .DEPTH(2)) u_dut3 (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus3)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       gt;
    logic       lt;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] exp_wrap;
    logic [5:0] exp_sat;
    logic       exp_ovf;
  } vec_t;

  typedef struct {
    logic [2:0]  gt;
    logic [2:0]  lt;
    logic [17:0] a;
    logic [17:0] b;
    logic [17:0] exp_wrap;
    logic [17:0] exp_sat;
    logic [2:0]  exp_ovf;
  } vec3_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  vec_t  vecs  [11];
  vec3_t vecs3 [2];

  initial begin
    logic [5:0]  exp1;
    logic [17:0] exp3;

    //            gt    lt    a      b      wrap   sat    ovf
    vecs[0]  = '{1'b1, 1'b0, 6'd5,  6'd3,  6'd8,  6'd8,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 6'd5,  6'd7,  6'h3E, 6'h3E, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 6'd12, 6'd20, 6'd12, 6'd12, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 6'd2,  6'd3,  6'd5,  6'd5,  1'b0};
    vecs[4]  = '{1'b1, 1'b0, 6'd31, 6'd1,  6'h20, 6'h1F, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 6'h20, 6'd1,  6'h1F, 6'h20, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 6'h20, 6'h3F, 6'h1F, 6'h20, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 6'h1F, 6'h3F, 6'h20, 6'h1F, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 6'h3D, 6'h02, 6'h3F, 6'h3F, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 6'h0A, 6'h3B, 6'h0F, 6'h0F, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6'h20, 6'h1F, 6'h20, 6'h20, 1'b0};

    // lane2 PASS 9, lane1 SUB 4-6, lane0 ADD 1+1
    vecs3[0] = '{3'b001, 3'b010, {6'd9, 6'd4, 6'd1}, {6'd0, 6'd6, 6'd1},
                 {6'd9, 6'h3E, 6'd2}, {6'd9, 6'h3E, 6'd2}, 3'b000};
    // lane2 PASS -32, lane1 SUB 0-1, lane0 ADD 31+1 (overflow)
    vecs3[1] = '{3'b001, 3'b010, {6'h20, 6'd0, 6'd31}, {6'd5, 6'd1, 6'd1},
                 {6'h20, 6'h3F, 6'h20}, {6'h20, 6'h3F, 6'h1F}, 3'b001};

    bus1.in_valid = 1'b0; bus1.ha_mem = '0; bus1.ha_mux = '0;
    bus1.gt = '0; bus1.lt = '0; bus1.out_ready = 1'b1;
    bus3.in_valid = 1'b0; bus3.ha_mem = '0; bus3.ha_mux = '0;
    bus3.gt = '0; bus3.lt = '0; bus3.out_ready = 1'b1;

    RST_N = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    chk("rst_out_valid", 32'(bus1.out_valid), 32'd0);
    chk("rst_count", 32'(bus1.count), 32'd0);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk("rst_sum", 32'(bus1.sum), 32'd0);

    // Single-lane table: one beat at a time, latency checked on every beat.
    for (int i = 0; i < 11; i++) begin
`ifdef CORDIC_ADDSUB_SAT_EN
      exp1 = vecs[i].exp_sat;
`else
      exp1 = vecs[i].exp_wrap;
`endif
      @(negedge CLK);
      bus1.gt = vecs[i].gt; bus1.lt = vecs[i].lt;
      bus1.ha_mem = vecs[i].a; bus1.ha_mux = vecs[i].b;
      bus1.in_valid = 1'b1;
      @(posedge CLK);
      #1 bus1.in_valid = 1'b0;
      @(negedge CLK);
      chk($sformatf("v%0d_lat1_valid", i), 32'(bus1.out_valid), 32'd0);
      chk($sformatf("v%0d_count", i), 32'(bus1.count), 32'd1);
      @(negedge CLK);
      chk($sformatf("v%0d_lat2_valid", i), 32'(bus1.out_valid), 32'd1);
      chk($sformatf("v%0d_sum", i), 32'(bus1.sum), 32'(exp1));
      chk($sformatf("v%0d_ovf", i), 32'(bus1.ovf), 32'(vecs[i].exp_ovf));
    end
    @(negedge CLK);
    chk("drain_count", 32'(bus1.count), 32'd0);

    // Three-lane beats.
    for (int i = 0; i < 2; i++) begin
`ifdef CORDIC_ADDSUB_SAT_EN
      exp3 = vecs3[i].exp_sat;
`else
      exp3 = vecs3[i].exp_wrap;
`endif
      @(negedge CLK);
      bus3.gt = vecs3[i].gt; bus3.lt = vecs3[i].lt;
      bus3.ha_mem = vecs3[i].a; bus3.ha_mux = vecs3[i].b;
      bus3.in_valid = 1'b1;
      @(posedge CLK);
      #1 bus3.in_valid = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      chk($sformatf("l3_%0d_valid", i), 32'(bus3.out_valid), 32'd1);
      chk($sformatf("l3_%0d_sum", i), 32'(bus3.sum), 32'(exp3));
      chk($sformatf("l3_%0d_ovf", i), 32'(bus3.ovf), 32'(vecs3[i].exp_ovf));
    end

    // Back-pressure: three beats offered to a stalled two-stage pipe.
    @(negedge CLK);
    bus1.out_ready = 1'b0;
    bus1.gt = 1'b1; bus1.lt = 1'b0; bus1.ha_mux = 6'd0;
    bus1.ha_mem = 6'd1; bus1.in_valid = 1'b1;
    chk("stall_b1_ready", 32'(bus1.in_ready), 32'd1);
    @(negedge CLK);
    bus1.ha_mem = 6'd2;
    chk("stall_b2_ready", 32'(bus1.in_ready), 32'd1);
    @(negedge CLK);
    bus1.ha_mem = 6'd3;
    chk("full_ready", 32'(bus1.in_ready), 32'd0);
    chk("full_count", 32'(bus1.count), 32'd2);
    chk("full_sum", 32'(bus1.sum), 32'd1);
    @(negedge CLK);
    chk("full_hold_ready", 32'(bus1.in_ready), 32'd0);
    chk("full_hold_count", 32'(bus1.count), 32'd2);
    chk("full_hold_sum", 32'(bus1.sum), 32'd1);
    bus1.out_ready = 1'b1;
    #1 chk("release_ready", 32'(bus1.in_ready), 32'd1);
    @(negedge CLK);
    bus1.in_valid = 1'b0;
    chk("rel_b2_valid", 32'(bus1.out_valid), 32'd1);
    chk("rel_b2_sum", 32'(bus1.sum), 32'd2);
    chk("rel_b2_count", 32'(bus1.count), 32'd2);
    @(negedge CLK);
    chk("rel_b3_valid", 32'(bus1.out_valid), 32'd1);
    chk("rel_b3_sum", 32'(bus1.sum), 32'd3);
    chk("rel_b3_count", 32'(bus1.count), 32'd1);
    @(negedge CLK);
    chk("rel_empty_valid", 32'(bus1.out_valid), 32'd0);
    chk("rel_empty_count", 32'(bus1.count), 32'd0);

    // Asynchronous reset with two beats in flight.
    bus1.out_ready = 1'b0;
    bus1.ha_mem = 6'd7; bus1.in_valid = 1'b1;
    @(negedge CLK);
    bus1.ha_mem = 6'd9;
    @(negedge CLK);
    bus1.in_valid = 1'b0;
    chk("pre_rst_count", 32'(bus1.count), 32'd2);
    chk("pre_rst_valid", 32'(bus1.out_valid), 32'd1);
    #2 RST_N = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus1.out_valid), 32'd0);
    chk("async_rst_count", 32'(bus1.count), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    bus1.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("post_rst_valid_%0d", c), 32'(bus1.out_valid), 32'd0);
    end
    chk("post_rst_count", 32'(bus1.count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
